// File: rtl/osd_dii_packet_arbiter.sv
// Packet-level round-robin arbiter: N dii_flit streams onto one DII link.
// A grant is held from the first accepted flit through the flit with last,
// so packets never interleave. One registered output stage (obuf) gives
// 1-cycle latency and full throughput under back-pressure.

package osd_dii_pkg;
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;
endpackage

module osd_dii_packet_arbiter
   import osd_dii_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  dii_flit [N-1:0]  in_flit,
   output logic    [N-1:0]  in_ready,
   output dii_flit          debug_out,
   input  logic             debug_out_ready,
   output logic             busy,
   output logic    [IW-1:0] grant_idx
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   dii_flit       obuf;

   logic [N-1:0]  valids;
   logic          any_valid;
   logic [IW-1:0] winner;
   logic [IW-1:0] sel_idx;
   logic [IW-1:0] nxt_ptr;
   logic          can_accept;
   logic          xfer;
   dii_flit       sel_flit;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_vld
         assign valids[gi] = in_flit[gi].valid;
      end
   endgenerate

   assign debug_out  = obuf;
   assign busy       = (state == LOCKED);
   assign can_accept = !obuf.valid || debug_out_ready;

   // Round-robin pick: scan ptr, ptr+1, ... wrapping; scanning backwards
   // lets the last assignment be the first valid in priority order.
   always_comb begin
      logic [IW-1:0] idx;
      any_valid = 1'b0;
      winner    = '0;
      idx       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % N);
         if (valids[idx]) begin
            any_valid = 1'b1;
            winner    = idx;
         end
      end
   end

   // Accept strobes: at most one input, never while reset or stalled.
   always_comb begin
      in_ready = '0;
      if (!rst && can_accept) begin
         if (state == LOCKED)
            in_ready[grant_idx] = 1'b1;
         else if (any_valid)
            in_ready[winner] = 1'b1;
      end
   end

   assign sel_idx  = (state == LOCKED) ? grant_idx : winner;
   assign sel_flit = in_flit[sel_idx];
   assign xfer     = in_ready[sel_idx] && sel_flit.valid;
   assign nxt_ptr  = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + IW'(1);

   // Output register plus IDLE/LOCKED packet-grant state machine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         obuf      <= '0;
         state     <= IDLE;
         ptr       <= '0;
         grant_idx <= '0;
      end else begin
         if (xfer)
            obuf <= sel_flit;
         else if (obuf.valid && debug_out_ready)
            obuf.valid <= 1'b0;

         case (state)
            IDLE: begin
               if (xfer) begin
                  grant_idx <= winner;
                  if (sel_flit.last)
                     ptr <= nxt_ptr;
                  else
                     state <= LOCKED;
               end
            end
            LOCKED: begin
               if (xfer && sel_flit.last) begin
                  state <= IDLE;
                  ptr   <= nxt_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_osd_dii_packet_arbiter.sv
// Bench: directed cycle table on an N=2 arbiter, hand sequences for pointer
// wrap and async reset on an N=3 arbiter, then random traffic against a
// packet-level reference model.

module tb_osd_dii_packet_arbiter;
   import osd_dii_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // N=2 instance
   dii_flit [1:0] f2;
   logic    [1:0] rdy2;
   dii_flit       o2;
   logic          dr2, busy2;
   logic    [0:0] g2;

   // N=3 instance
   dii_flit [2:0] f3;
   logic    [2:0] rdy3;
   dii_flit       o3;
   logic          dr3, busy3;
   logic    [1:0] g3;

   osd_dii_packet_arbiter #(.N(2)) u2 (
      .clk(clk), .rst(rst), .in_flit(f2), .in_ready(rdy2),
      .debug_out(o2), .debug_out_ready(dr2), .busy(busy2), .grant_idx(g2));

   osd_dii_packet_arbiter #(.N(3)) u3 (
      .clk(clk), .rst(rst), .in_flit(f3), .in_ready(rdy3),
      .debug_out(o3), .debug_out_ready(dr3), .busy(busy3), .grant_idx(g3));

   int pass_cnt = 0;
   int tot_cnt  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic dii_flit mkf(input logic v, input logic l, input logic [15:0] d);
      dii_flit f;
      f.valid = v; f.last = l; f.data = d;
      return f;
   endfunction

   typedef struct {
      logic v0, l0; logic [15:0] d0;
      logic v1, l1; logic [15:0] d1;
      logic dr;
      logic [1:0] rdy;
      logic ov, ol; logic [15:0] od;
      logic busy; logic g;
   } vec_t;

   vec_t vt[16];

   // reference model state for the random phase (N=3)
   bit         m_locked;
   int         m_grant, m_ptr;
   bit         m_ov, m_ol;
   int         m_od;
   int         rem[3];
   logic [15:0] cur_d[3];

   initial begin
      // single packet, lock hold, back-pressure, pointer after packet
      vt[0]  = '{1,0,16'h4001, 0,0,16'h0, 1, 2'b01, 0,0,16'h0,    0,0};
      vt[1]  = '{1,0,16'h1234, 0,0,16'h0, 1, 2'b01, 1,0,16'h4001, 1,0};
      vt[2]  = '{1,1,16'h00AB, 0,0,16'h0, 1, 2'b01, 1,0,16'h1234, 1,0};
      vt[3]  = '{0,0,16'h0,    0,0,16'h0, 1, 2'b00, 1,1,16'h00AB, 0,0};
      vt[4]  = '{1,1,16'h0A00, 1,1,16'h0B00, 1, 2'b10, 0,0,16'h0, 0,0};
      vt[5]  = '{1,1,16'h0A00, 1,1,16'h0B01, 1, 2'b01, 1,1,16'h0B00, 0,1};
      vt[6]  = '{1,0,16'h0C00, 0,0,16'h0,    1, 2'b01, 1,1,16'h0A00, 0,0};
      vt[7]  = '{1,0,16'h0C01, 1,1,16'h0D00, 1, 2'b01, 1,0,16'h0C00, 1,0};
      for (int i = 8; i < 12; i++)
         vt[i] = '{1,1,16'h0C02, 1,1,16'h0D00, 0, 2'b00, 1,0,16'h0C01, 1,0};
      vt[12] = '{1,1,16'h0C02, 1,1,16'h0D00, 1, 2'b01, 1,0,16'h0C01, 1,0};
      vt[13] = '{0,0,16'h0,    1,1,16'h0D00, 1, 2'b10, 1,1,16'h0C02, 0,0};
      vt[14] = '{0,0,16'h0,    0,0,16'h0,    1, 2'b00, 1,1,16'h0D00, 0,1};
      vt[15] = '{0,0,16'h0,    0,0,16'h0,    1, 2'b00, 0,0,16'h0,    0,1};

      f2 = '0; f3 = '0; dr2 = 1'b1; dr3 = 1'b1;
      #12;
      // reset state (inputs idle)
      chk("rst u2 out", 32'(o2), 32'h0);
      chk("rst u2 busy", 32'(busy2), 32'h0);
      chk("rst u2 grant", 32'(g2), 32'h0);
      chk("rst u2 rdy", 32'(rdy2), 32'h0);
      chk("rst u3 out", 32'(o3), 32'h0);
      @(negedge clk); rst = 1'b0;

      // directed table on N=2
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         f2[0] = mkf(vt[i].v0, vt[i].l0, vt[i].d0);
         f2[1] = mkf(vt[i].v1, vt[i].l1, vt[i].d1);
         dr2   = vt[i].dr;
         #1;
         chk($sformatf("v%0d rdy", i),   32'(rdy2),      32'(vt[i].rdy));
         chk($sformatf("v%0d ovld", i),  32'(o2.valid),  32'(vt[i].ov));
         if (vt[i].ov) begin
            chk($sformatf("v%0d odata", i), 32'(o2.data), 32'(vt[i].od));
            chk($sformatf("v%0d olast", i), 32'(o2.last), 32'(vt[i].ol));
         end
         chk($sformatf("v%0d busy", i),  32'(busy2),     32'(vt[i].busy));
         chk($sformatf("v%0d grant", i), 32'(g2),        32'(vt[i].g));
      end
      f2 = '0;

      // N=3 pointer wrap: grant 1 -> ptr=2; inputs 0,1 valid -> 0 wins, then 1
      @(negedge clk); f3[1] = mkf(1, 1, 16'h1111); #1;
      chk("wrap rdy a", 32'(rdy3), 32'h2);
      @(negedge clk); f3[0] = mkf(1, 1, 16'h2220); f3[1] = mkf(1, 1, 16'h2221); #1;
      chk("wrap rdy b", 32'(rdy3), 32'h1);
      chk("wrap out a", 32'(o3.data), 32'h1111);
      @(negedge clk); f3[0] = mkf(1, 1, 16'h2222); #1;
      chk("wrap rdy c", 32'(rdy3), 32'h2);
      chk("wrap out b", 32'(o3.data), 32'h2220);
      @(negedge clk); f3 = '0; #1;
      chk("wrap out c", 32'(o3.data), 32'h2221);
      chk("wrap grant", 32'(g3), 32'h1);

      // async reset mid-packet
      @(negedge clk); f3[0] = mkf(1, 0, 16'h3000);
      @(negedge clk); f3[0] = mkf(1, 0, 16'h3001); #1;
      chk("mid busy", 32'(busy3), 32'h1);
      #1 rst = 1'b1; #1;
      chk("arst ovld", 32'(o3.valid), 32'h0);
      chk("arst busy", 32'(busy3), 32'h0);
      chk("arst rdy", 32'(rdy3), 32'h0);
      @(negedge clk); rst = 1'b0; f3[0] = '0; f3[1] = mkf(1, 0, 16'h5000); #1;
      chk("post rdy", 32'(rdy3), 32'h2);
      @(negedge clk); f3[1] = mkf(1, 1, 16'h5001); #1;
      chk("post out a", 32'(o3), 32'(mkf(1, 0, 16'h5000)));
      chk("post busy", 32'(busy3), 32'h1);
      @(negedge clk); f3 = '0; #1;
      chk("post out b", 32'(o3), 32'(mkf(1, 1, 16'h5001)));
      chk("post idle", 32'(busy3), 32'h0);

      // random traffic vs packet-level model
      @(negedge clk); rst = 1'b1; #1 rst = 1'b0;
      m_locked = 0; m_grant = 0; m_ptr = 0; m_ov = 0; m_ol = 0; m_od = 0;
      for (int i = 0; i < 3; i++) begin
         rem[i] = $urandom_range(1, 4); cur_d[i] = 16'($urandom_range(0, 65535));
      end
      for (int c = 0; c < 400; c++) begin
         logic [2:0] exp_rdy;
         int pick;
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            f3[i] = mkf($urandom_range(0, 9) < 7, rem[i] == 1, cur_d[i]);
         dr3 = ($urandom_range(0, 3) != 0);
         #1;
         exp_rdy = '0; pick = -1;
         if (!m_ov || dr3) begin
            if (m_locked) pick = m_grant;
            else
               for (int k = 0; k < 3; k++)
                  if (pick < 0 && f3[(m_ptr + k) % 3].valid) pick = (m_ptr + k) % 3;
            if (pick >= 0) exp_rdy[pick] = 1'b1;
         end
         chk($sformatf("r%0d rdy", c),  32'(rdy3),     32'(exp_rdy));
         chk($sformatf("r%0d ovld", c), 32'(o3.valid), 32'(m_ov));
         if (m_ov) begin
            chk($sformatf("r%0d odata", c), 32'(o3.data), 32'(m_od));
            chk($sformatf("r%0d olast", c), 32'(o3.last), 32'(m_ol));
         end
         chk($sformatf("r%0d busy", c),  32'(busy3), 32'(m_locked));
         chk($sformatf("r%0d grant", c), 32'(g3),    32'(m_grant));
         if (pick >= 0 && f3[pick].valid) begin
            m_ov = 1; m_od = int'(cur_d[pick]); m_ol = (rem[pick] == 1);
            m_grant = pick;
            if (m_ol) begin m_locked = 0; m_ptr = (pick + 1) % 3; end
            else m_locked = 1;
            rem[pick]--;
            if (rem[pick] == 0) rem[pick] = $urandom_range(1, 4);
            cur_d[pick] = 16'($urandom_range(0, 65535));
         end else if (m_ov && dr3) m_ov = 0;
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
